// File: rtl/spi_slave_rx_param_if.sv
`default_nettype none
// ============================================================================
// spi_slave_rx_param_if : bus bundle for the parametrised SPI slave receiver.
// Optional MISO return signals exist only when SPI_SLV_MISO_EN is defined.
// Revision: 1.0
// ============================================================================
interface spi_slave_rx_param_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 8
) ();
  logic              cs;
  logic              mosi;
  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic [CNT_W-1:0]  word_cnt;
  logic              busy;
  logic              frame_err;
`ifdef SPI_SLV_MISO_EN
  logic [WORD_W-1:0] tx_data;
  logic              miso;
`endif

  modport master (
    output cs, mosi,
`ifdef SPI_SLV_MISO_EN
    output tx_data,
    input  miso,
`endif
    input  dout, dout_valid, word_cnt, busy, frame_err
  );

  modport slave (
    input  cs, mosi,
`ifdef SPI_SLV_MISO_EN
    input  tx_data,
    output miso,
`endif
    output dout, dout_valid, word_cnt, busy, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_rx_param.sv
`default_nettype none
// ============================================================================
// spi_slave_rx_param : SPI slave deserialiser clocked by sclk, configurable
// word width / bit order, optional MISO return path (macro SPI_SLV_MISO_EN).
// Revision: 1.0
// ============================================================================
module spi_slave_rx_param #(
  parameter int WORD_W    = 32,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  wire logic           sclk,
  input  wire logic           rst_n,
  spi_slave_rx_param_if.slave bus
);
  localparam int                C_BC_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [C_BC_W-1:0] C_LAST = C_BC_W'(WORD_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic [C_BC_W-1:0] r_bit_cnt,  w_bit_cnt_nxt;
  logic [WORD_W-1:0] r_shift,    w_shift_nxt;
  logic [WORD_W-1:0] r_dout,     w_dout_nxt;
  logic [CNT_W-1:0]  r_word_cnt, w_word_cnt_nxt;
  logic              r_valid,    w_valid_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_err,      w_err_nxt;
  logic [WORD_W-1:0] w_word;

  // Word as it stands once the current mosi bit is included.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_word = {r_shift[WORD_W-2:0], bus.mosi};
    end else begin : g_lsb_first
      assign w_word = {bus.mosi, r_shift[WORD_W-1:1]};
    end
  endgenerate

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_dout     <= '0;
      r_word_cnt <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_dout     <= w_dout_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // The state entered at each edge is chosen by chip select alone.
  always_comb begin
    w_state_nxt    = bus.cs ? ST_IDLE : ST_SHIFT;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_dout_nxt     = r_dout;
    w_word_cnt_nxt = r_word_cnt;
    w_valid_nxt    = 1'b0;
    w_busy_nxt     = r_busy;
    w_err_nxt      = r_err;
    case (w_state_nxt)
      ST_IDLE: begin
        w_bit_cnt_nxt  = '0;
        w_shift_nxt    = '0;
        w_word_cnt_nxt = '0;
        w_busy_nxt     = 1'b0;
        if (r_state == ST_SHIFT && r_bit_cnt != '0) begin
          w_err_nxt = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_shift_nxt = w_word;
        if (r_bit_cnt == C_LAST) begin
          w_dout_nxt     = w_word;
          w_valid_nxt    = 1'b1;
          w_bit_cnt_nxt  = '0;
          w_busy_nxt     = 1'b0;
          w_word_cnt_nxt = (&r_word_cnt) ? r_word_cnt : r_word_cnt + 1'b1;
          w_err_nxt      = 1'b0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end
      default: begin
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.word_cnt   = r_word_cnt;
  assign bus.busy       = r_busy;
  assign bus.frame_err  = r_err;

`ifdef SPI_SLV_MISO_EN
  // tx_shift holds the word pre-advanced by one bit; its edge bit is the next to go out.
  logic [WORD_W-1:0] r_tx_shift;
  logic              w_tx_first;
  logic              w_tx_next;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= '0;
    end else if (!bus.cs) begin
      if (r_bit_cnt == '0) begin
        r_tx_shift <= MSB_FIRST ? (bus.tx_data << 1) : (bus.tx_data >> 1);
      end else begin
        r_tx_shift <= MSB_FIRST ? (r_tx_shift << 1) : (r_tx_shift >> 1);
      end
    end
  end

  assign w_tx_first = MSB_FIRST ? bus.tx_data[WORD_W-1] : bus.tx_data[0];
  assign w_tx_next  = MSB_FIRST ? r_tx_shift[WORD_W-1]  : r_tx_shift[0];
  assign bus.miso   = rst_n & ~bus.cs & ((r_bit_cnt == '0) ? w_tx_first : w_tx_next);
`endif
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx_param.sv
`default_nettype none
// ============================================================================
// tb_spi_slave_rx_param : randomized bench for spi_slave_rx_param, comparing a
// 32-bit MSB-first and an 8-bit LSB-first instance against a bit-list model.
// Revision: 1.0
// ============================================================================
module tb_spi_slave_rx_param;
  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  spi_slave_rx_param_if #(.WORD_W(32), .CNT_W(8)) bus_a ();
  spi_slave_rx_param_if #(.WORD_W(8),  .CNT_W(8)) bus_b ();

  spi_slave_rx_param #(.WORD_W(32), .MSB_FIRST(1'b1), .CNT_W(8)) u_dut_a (
    .sclk(sclk), .rst_n(rst_n), .bus(bus_a));
  spi_slave_rx_param #(.WORD_W(8),  .MSB_FIRST(1'b0), .CNT_W(8)) u_dut_b (
    .sclk(sclk), .rst_n(rst_n), .bus(bus_b));

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] tx_a = 32'h0;
  logic [7:0]  tx_b = 8'h0;

  // Model: bits of the current word kept in arrival order, plus frame results.
  int          c_w   [2] = '{32, 8};
  bit          c_msb [2] = '{1'b1, 1'b0};
  logic [31:0] m_bits[2];
  int          m_n   [2];
  logic [31:0] m_dout[2];
  logic [31:0] m_txl [2];
  bit          m_valid[2];
  int          m_cnt [2];
  bit          m_err [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_bits[i] = '0; m_n[i] = 0; m_dout[i] = '0; m_txl[i] = '0;
      m_valid[i] = 1'b0; m_cnt[i] = 0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i, input logic c, input logic d, input logic [31:0] tx);
    logic [31:0] word;
    m_valid[i] = 1'b0;
    if (c) begin
      if (m_n[i] != 0) m_err[i] = 1'b1;
      m_n[i] = 0;
      m_cnt[i] = 0;
    end else begin
      if (m_n[i] == 0) m_txl[i] = tx;
      m_bits[i][m_n[i]] = d;
      m_n[i]++;
      if (m_n[i] == c_w[i]) begin
        word = '0;
        for (int k = 0; k < c_w[i]; k++) begin
          if (c_msb[i]) word[c_w[i]-1-k] = m_bits[i][k];
          else          word[k]          = m_bits[i][k];
        end
        m_dout[i]  = word;
        m_valid[i] = 1'b1;
        if (m_cnt[i] < 255) m_cnt[i]++;
        m_err[i] = 1'b0;
        m_n[i]   = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " a.dout"},      64'(bus_a.dout),       64'(m_dout[0]));
    chk({tag, " a.valid"},     64'(bus_a.dout_valid), 64'(m_valid[0]));
    chk({tag, " a.word_cnt"},  64'(bus_a.word_cnt),   64'(m_cnt[0]));
    chk({tag, " a.busy"},      64'(bus_a.busy),       64'(m_n[0] != 0));
    chk({tag, " a.frame_err"}, 64'(bus_a.frame_err),  64'(m_err[0]));
    chk({tag, " b.dout"},      64'(bus_b.dout),       64'(m_dout[1][7:0]));
    chk({tag, " b.valid"},     64'(bus_b.dout_valid), 64'(m_valid[1]));
    chk({tag, " b.word_cnt"},  64'(bus_b.word_cnt),   64'(m_cnt[1]));
    chk({tag, " b.busy"},      64'(bus_b.busy),       64'(m_n[1] != 0));
    chk({tag, " b.frame_err"}, 64'(bus_b.frame_err),  64'(m_err[1]));
`ifdef SPI_SLV_MISO_EN
    chk({tag, " a.miso"}, 64'(bus_a.miso),
        64'((!rst_n || bus_a.cs) ? 1'b0 :
            (m_n[0] == 0) ? tx_a[31] : m_txl[0][31-m_n[0]]));
    chk({tag, " b.miso"}, 64'(bus_b.miso),
        64'((!rst_n || bus_b.cs) ? 1'b0 :
            (m_n[1] == 0) ? tx_b[0] : m_txl[1][m_n[1]]));
`endif
  endtask

  // Called at a falling edge: drive, let one rising edge happen, check at the next fall.
  task automatic step(input logic ca, input logic da, input logic cb, input logic db,
                      input string tag);
    bus_a.cs = ca; bus_a.mosi = da;
    bus_b.cs = cb; bus_b.mosi = db;
`ifdef SPI_SLV_MISO_EN
    bus_a.tx_data = tx_a;
    bus_b.tx_data = tx_b;
`endif
    @(posedge sclk);
    model_edge(0, ca, da, tx_a);
    model_edge(1, cb, db, {24'h0, tx_b});
    @(negedge sclk);
    check_all(tag);
  endtask

  task automatic send_a(input logic [31:0] word, input string tag);
    for (int k = 0; k < 32; k++) step(1'b0, word[31-k], 1'b1, 1'b0, tag);
  endtask

  task automatic send_b(input logic [7:0] bits_in_order, input string tag);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, bits_in_order[k], tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] burst [3];
    bit ca, cb;
    burst[0] = 32'h1; burst[1] = 32'h2; burst[2] = 32'hFFFF_FFFF;
    bus_a.cs = 1'b1; bus_a.mosi = 1'b0;
    bus_b.cs = 1'b1; bus_b.mosi = 1'b0;
`ifdef SPI_SLV_MISO_EN
    bus_a.tx_data = '0; bus_b.tx_data = '0;
`endif
    model_reset();
    repeat (3) @(negedge sclk);
    check_all("reset");
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, "idle");

    send_a(32'hA5A5_0F0F, "t1");
    chk("t1 dout", 64'(bus_a.dout), 64'h A5A5_0F0F);
    chk("t1 cnt",  64'(bus_a.word_cnt), 64'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, "t1 end");

    for (int j = 0; j < 3; j++) begin
      send_a(burst[j], "t2");
      chk("t2 dout", 64'(bus_a.dout), 64'(burst[j]));
    end
    chk("t2 cnt", 64'(bus_a.word_cnt), 64'd3);
    step(1'b1, 1'b0, 1'b1, 1'b0, "t2 end");

    send_b(8'b0000_0001, "t3");
    chk("t3 dout", 64'(bus_b.dout), 64'h01);
    step(1'b1, 1'b0, 1'b1, 1'b0, "t3 end");

    for (int k = 0; k < 12; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, "t4 bits");
    step(1'b1, 1'b0, 1'b1, 1'b0, "t4 abort");
    chk("t4 err", 64'(bus_a.frame_err), 64'd1);
    chk("t4 cnt", 64'(bus_a.word_cnt), 64'd0);
    send_a(32'hDEAD_BEEF, "t4 recover");
    chk("t4 err clr", 64'(bus_a.frame_err), 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, "t4 end");

    for (int k = 0; k < 20; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, "t5 bits");
    #2 rst_n = 1'b0;
    #1;
    chk("t5 dout", 64'(bus_a.dout), 64'd0);
    chk("t5 busy", 64'(bus_a.busy), 64'd0);
    chk("t5 cnt",  64'(bus_a.word_cnt), 64'd0);
`ifdef SPI_SLV_MISO_EN
    chk("t5 miso", 64'(bus_a.miso), 64'd0);
`endif
    model_reset();
    @(negedge sclk);
    check_all("t5 in reset");
    rst_n = 1'b1;
    w = $urandom;
    send_a(w, "t5 recover");
    chk("t5 word", 64'(bus_a.dout), 64'(w));
    step(1'b1, 1'b0, 1'b1, 1'b0, "t5 end");

    tx_a = 32'hC3C3_C3C3;
    tx_b = 8'h5A;
    send_a(32'h1234_5678, "t6");
    chk("t6 dout", 64'(bus_a.dout), 64'h1234_5678);
    step(1'b1, 1'b0, 1'b1, 1'b0, "t6 end");

    for (int k = 0; k < 260 * 8; k++) step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), "sat");
    chk("sat cnt", 64'(bus_b.word_cnt), 64'd255);
    step(1'b1, 1'b0, 1'b1, 1'b0, "sat end");

    ca = 1'b1; cb = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (ca) ca = ($urandom_range(0, 3) != 0);
      else    ca = ($urandom_range(0, 39) == 0);
      if (cb) cb = ($urandom_range(0, 3) != 0);
      else    cb = ($urandom_range(0, 29) == 0);
      tx_a = $urandom;
      tx_b = 8'($urandom);
      step(ca, 1'($urandom_range(0, 1)), cb, 1'($urandom_range(0, 1)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
